// File: rtl/spart_if.sv
// ---------------------------------------------------------------------------
// spart_if -- processor-side control bundle for the SPART.
//
// Groups the chip-select / direction / register-select strobes driven by the
// host together with the two status flags the SPART reports back. The 8-bit
// bidirectional data bus is a plain inout port on the SPART itself, because
// it is a resolved tri-state net shared by both sides.
//
// Signals:
//   iocs    host -> SPART  chip select, accesses happen only while high
//   iorw    host -> SPART  1 = read (SPART drives databus), 0 = write
//   ioaddr  host -> SPART  00 TX/RX buffer, 01 status, 10 div low, 11 div high
//   rda     SPART -> host  receive data available
//   tbr     SPART -> host  transmit buffer ready
// ---------------------------------------------------------------------------
interface spart_if;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic       rda;
  logic       tbr;

  // The host owns the strobes and watches the flags.
  modport master (
    output iocs,
    output iorw,
    output ioaddr,
    input  rda,
    input  tbr
  );

  // The SPART watches the strobes and owns the flags.
  modport slave (
    input  iocs,
    input  iorw,
    input  ioaddr,
    output rda,
    output tbr
  );
endinterface

// File: rtl/spart.sv
// ---------------------------------------------------------------------------
// spart -- Special Purpose Asynchronous Receiver/Transmitter.
//
// A small full-duplex 8N1 UART with a host register interface:
//   addr 00  write: byte to transmit (only accepted while tbr=1)
//            read : last received byte (reading clears rda)
//   addr 01  read : {6'b0, tbr, rda}
//   addr 10  read/write: baud divisor low byte
//   addr 11  read/write: baud divisor high byte
//
// A programmable divisor produces a one-clock baud enable; sixteen enables
// make one bit time. Transmitter and receiver are independent state machines
// that share only that enable.
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset
//   bus      spart_if.slave: iocs, iorw, ioaddr in; rda, tbr out
//   databus  8-bit bidirectional data bus, driven only on reads
//   txd      serial output, idle high
//   rxd      serial input, idle high (double-synchronised internally)
// ---------------------------------------------------------------------------
module spart #(
  parameter logic [15:0] DEFAULT_DIVISOR = 16'h028B
) (
  input  logic       clk,
  input  logic       rst,
  spart_if.slave     bus,
  inout  wire  [7:0] databus,
  output logic       txd,
  input  logic       rxd
);

  // A divisor of zero behaves like one: the enable then fires every clock.
  localparam logic [15:0] RESET_RELOAD =
    (DEFAULT_DIVISOR == 16'd0) ? 16'd0 : (DEFAULT_DIVISOR - 16'd1);

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } txState_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rxState_t;

  // -------------------------------------------------------------------------
  // Register state
  // -------------------------------------------------------------------------
  logic [15:0] divisor_q;
  logic [15:0] divisor_d;
  logic [15:0] baudCnt_q;
  logic [15:0] baudReload;
  logic        baudEn;

  txState_t    txState_q;
  logic [7:0]  txShift_q;
  logic [2:0]  txBitCnt_q;
  logic [3:0]  txTick_q;
  logic        txPending_q;
  logic        tbr_q;
  logic        txd_q;

  logic        rxSync1_q;
  logic        rxSync2_q;
  rxState_t    rxState_q;
  logic [7:0]  rxShift_q;
  logic [2:0]  rxBitCnt_q;
  logic [3:0]  rxTick_q;
  logic [7:0]  rxBuf_q;
  logic        rda_q;

  logic        wrAccess;
  logic        rdAccess;
  logic        wrTx;
  logic        wrDivLo;
  logic        wrDivHi;
  logic        divWrite;
  logic        rdRx;
  logic [7:0]  readData;

  // -------------------------------------------------------------------------
  // Bus decode
  // -------------------------------------------------------------------------
  assign wrAccess = bus.iocs & ~bus.iorw;
  assign rdAccess = bus.iocs &  bus.iorw;
  assign wrTx     = wrAccess && (bus.ioaddr == 2'b00);
  assign wrDivLo  = wrAccess && (bus.ioaddr == 2'b10);
  assign wrDivHi  = wrAccess && (bus.ioaddr == 2'b11);
  assign divWrite = wrDivLo | wrDivHi;
  assign rdRx     = rdAccess && (bus.ioaddr == 2'b00);

  // The divisor seen by the baud counter this cycle already includes any byte
  // being written, so a divisor write restarts the counter at the new rate.
  always_comb begin
    divisor_d = divisor_q;
    if (wrDivLo) divisor_d[7:0]  = databus;
    if (wrDivHi) divisor_d[15:8] = databus;
  end

  assign baudReload = (divisor_d == 16'd0) ? 16'd0 : (divisor_d - 16'd1);

  // The enable is suppressed in the cycle of a divisor write: that write
  // restarts the count, so the old period is abandoned without a pulse.
  assign baudEn = (baudCnt_q == 16'd0) && !divWrite;

  // -------------------------------------------------------------------------
  // Divisor register and baud counter
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      divisor_q <= DEFAULT_DIVISOR;
      baudCnt_q <= RESET_RELOAD;
    end else begin
      divisor_q <= divisor_d;
      if (divWrite || (baudCnt_q == 16'd0)) begin
        baudCnt_q <= baudReload;
      end else begin
        baudCnt_q <= baudCnt_q - 16'd1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Transmitter
  // A byte is latched from the bus only while tbr is high; it then waits in
  // txPending_q for the next baud enable so the start bit is enable-aligned.
  // txTick_q counts enables within the current bit; the 16th enable (tick 15)
  // moves to the next bit. tbr only returns once the stop bit is complete.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txState_q   <= TX_IDLE;
      txShift_q   <= 8'h00;
      txBitCnt_q  <= 3'd0;
      txTick_q    <= 4'd0;
      txPending_q <= 1'b0;
      tbr_q       <= 1'b1;
      txd_q       <= 1'b1;
    end else begin
      if (wrTx && tbr_q) begin
        txShift_q   <= databus;
        txPending_q <= 1'b1;
        tbr_q       <= 1'b0;
      end
      if (baudEn) begin
        case (txState_q)
          TX_IDLE: begin
            if (txPending_q) begin
              txState_q   <= TX_START;
              txd_q       <= 1'b0;
              txTick_q    <= 4'd0;
              txPending_q <= 1'b0;
            end
          end
          TX_START: begin
            if (txTick_q == 4'd15) begin
              txState_q  <= TX_DATA;
              txd_q      <= txShift_q[0];
              txTick_q   <= 4'd0;
              txBitCnt_q <= 3'd0;
            end else begin
              txTick_q <= txTick_q + 4'd1;
            end
          end
          TX_DATA: begin
            if (txTick_q == 4'd15) begin
              txTick_q <= 4'd0;
              if (txBitCnt_q == 3'd7) begin
                txState_q <= TX_STOP;
                txd_q     <= 1'b1;
              end else begin
                // Bit 0 of the shifter is always the bit on the wire.
                txShift_q  <= {1'b0, txShift_q[7:1]};
                txd_q      <= txShift_q[1];
                txBitCnt_q <= txBitCnt_q + 3'd1;
              end
            end else begin
              txTick_q <= txTick_q + 4'd1;
            end
          end
          TX_STOP: begin
            if (txTick_q == 4'd15) begin
              txState_q <= TX_IDLE;
              txTick_q  <= 4'd0;
              tbr_q     <= 1'b1;
            end else begin
              txTick_q <= txTick_q + 4'd1;
            end
          end
          default: begin
            txState_q <= TX_IDLE;
          end
        endcase
      end
    end
  end

  // -------------------------------------------------------------------------
  // Receiver
  // rxd passes through two flops before anything looks at it. A falling edge
  // moves IDLE to START immediately; the line is re-checked at the 8th enable
  // (the middle of the start bit) so short glitches fall back to IDLE. From
  // there every 16th enable lands in the middle of the next bit.
  // rda: a read of the RX buffer clears it, but a byte completing in the same
  // cycle takes priority because its assignment comes later in the block.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxSync1_q  <= 1'b1;
      rxSync2_q  <= 1'b1;
      rxState_q  <= RX_IDLE;
      rxShift_q  <= 8'h00;
      rxBitCnt_q <= 3'd0;
      rxTick_q   <= 4'd0;
      rxBuf_q    <= 8'h00;
      rda_q      <= 1'b0;
    end else begin
      rxSync1_q <= rxd;
      rxSync2_q <= rxSync1_q;

      if (rdRx) begin
        rda_q <= 1'b0;
      end

      case (rxState_q)
        RX_IDLE: begin
          if (!rxSync2_q) begin
            rxState_q <= RX_START;
            rxTick_q  <= 4'd0;
          end
        end
        RX_START: begin
          if (baudEn) begin
            if (rxTick_q == 4'd7) begin
              rxTick_q   <= 4'd0;
              rxBitCnt_q <= 3'd0;
              rxState_q  <= rxSync2_q ? RX_IDLE : RX_DATA;
            end else begin
              rxTick_q <= rxTick_q + 4'd1;
            end
          end
        end
        RX_DATA: begin
          if (baudEn) begin
            if (rxTick_q == 4'd15) begin
              rxTick_q  <= 4'd0;
              rxShift_q <= {rxSync2_q, rxShift_q[7:1]};
              if (rxBitCnt_q == 3'd7) begin
                rxState_q <= RX_STOP;
              end else begin
                rxBitCnt_q <= rxBitCnt_q + 3'd1;
              end
            end else begin
              rxTick_q <= rxTick_q + 4'd1;
            end
          end
        end
        RX_STOP: begin
          if (baudEn) begin
            if (rxTick_q == 4'd15) begin
              rxTick_q  <= 4'd0;
              rxState_q <= RX_IDLE;
              // A low stop bit is a framing error: the byte is dropped and
              // rda is left as it was.
              if (rxSync2_q) begin
                rxBuf_q <= rxShift_q;
                rda_q   <= 1'b1;
              end
            end else begin
              rxTick_q <= rxTick_q + 4'd1;
            end
          end
        end
        default: begin
          rxState_q <= RX_IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Read mux and bus drivers
  // -------------------------------------------------------------------------
  always_comb begin
    readData = 8'h00;
    case (bus.ioaddr)
      2'b00:   readData = rxBuf_q;
      2'b01:   readData = {6'b000000, tbr_q, rda_q};
      2'b10:   readData = divisor_q[7:0];
      2'b11:   readData = divisor_q[15:8];
      default: readData = 8'h00;
    endcase
  end

  assign databus = rdAccess ? readData : 8'hzz;
  assign txd     = txd_q;
  assign bus.rda = rda_q;
  assign bus.tbr = tbr_q;

endmodule

// File: tb/tb_spart.sv
// ---------------------------------------------------------------------------
// tb_spart -- directed self-checking bench for the SPART.
//
// Drives the host strobes through a spart_if instance and the shared data bus
// through its own tri-state driver. rxd is either looped back from txd or
// driven directly by the bench to build arbitrary (and broken) frames.
// ---------------------------------------------------------------------------
module tb_spart;

  // Bit time used once the divisor is reprogrammed to 4: 16 enables x 4 clks.
  localparam int BIT_CLKS = 64;

  logic       clk = 1'b0;
  logic       rst;
  wire  [7:0] databus;
  logic       tbDrive;
  logic [7:0] tbData;
  logic       txd;
  logic       rxd;
  logic       loopEn;
  logic       rxDrive;

  int checks = 0;
  int errors = 0;

  spart_if bus ();

  assign databus = tbDrive ? tbData : 8'hzz;
  assign rxd     = loopEn ? txd : rxDrive;

  spart #(
    .DEFAULT_DIVISOR(16'h028B)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .databus(databus),
    .txd    (txd),
    .rxd    (rxd)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One host write cycle; the SPART captures it at the posedge in between.
  task automatic applyStimulus(input logic [1:0] addr, input logic [7:0] data);
    @(negedge clk);
    bus.ioaddr = addr;
    bus.iorw   = 1'b0;
    tbDrive    = 1'b1;
    tbData     = data;
    bus.iocs   = 1'b1;
    @(negedge clk);
    bus.iocs   = 1'b0;
    tbData     = 8'h00;
  endtask

  // One host read cycle; data is sampled mid-cycle, away from the edge.
  task automatic readBus(input logic [1:0] addr, output logic [7:0] data);
    @(negedge clk);
    bus.ioaddr = addr;
    bus.iorw   = 1'b1;
    tbDrive    = 1'b0;
    bus.iocs   = 1'b1;
    #2 data = databus;
    @(negedge clk);
    bus.iocs   = 1'b0;
    bus.iorw   = 1'b0;
    tbDrive    = 1'b1;
    tbData     = 8'h00;
  endtask

  task automatic readCheck(input string tag, input logic [1:0] addr,
                           input logic [7:0] expected);
    logic [7:0] value;
    readBus(addr, value);
    checkOutput(tag, value, expected);
  endtask

  // Bounded waits; an expired bound shows up as a failed comparison.
  task automatic waitTxdLow(input string tag, input int maxClks);
    int n;
    n = 0;
    while (txd !== 1'b0 && n < maxClks) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, txd, 1'b0);
  endtask

  task automatic waitRda(input string tag, input int maxClks);
    int n;
    n = 0;
    while (bus.rda !== 1'b1 && n < maxClks) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, bus.rda, 1'b1);
  endtask

  task automatic waitTbr(input string tag, input int maxClks);
    int n;
    n = 0;
    while (bus.tbr !== 1'b1 && n < maxClks) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, bus.tbr, 1'b1);
  endtask

  // Drives one frame on rxd; stopClks lets the stop bit be shortened.
  task automatic sendSerial(input logic [7:0] data, input logic stopBit,
                            input int stopClks);
    logic [9:0] frame;
    frame = {stopBit, data, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxDrive = frame[i];
      repeat ((i == 9) ? stopClks : BIT_CLKS) @(negedge clk);
    end
    rxDrive = 1'b1;
  endtask

  // Hard stop if anything above were to hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int         lowClks;
    logic [9:0] txFrame;

    rst        = 1'b1;
    bus.iocs   = 1'b0;
    bus.iorw   = 1'b0;
    bus.ioaddr = 2'b00;
    tbDrive    = 1'b1;
    tbData     = 8'h00;
    loopEn     = 1'b0;
    rxDrive    = 1'b1;

    // Reset state.
    repeat (3) @(negedge clk);
    checkOutput("reset txd", txd, 1'b1);
    checkOutput("reset tbr", bus.tbr, 1'b1);
    checkOutput("reset rda", bus.rda, 1'b0);
    rst = 1'b0;

    // Register reads after reset.
    readCheck("status after reset", 2'b01, 8'h02);
    readCheck("div low default", 2'b10, 8'h8B);
    readCheck("div high default", 2'b11, 8'h02);
    readCheck("rx buffer reset", 2'b00, 8'h00);

    // Bus released when not reading: only the bench driver (0x00) is seen.
    @(negedge clk);
    bus.ioaddr = 2'b10;
    bus.iorw   = 1'b1;
    bus.iocs   = 1'b0;
    #2 checkOutput("bus idle iocs=0", databus, 8'h00);
    @(negedge clk);
    bus.ioaddr = 2'b01;
    bus.iorw   = 1'b0;
    bus.iocs   = 1'b1;
    #2 checkOutput("bus idle iorw=0", databus, 8'h00);
    @(negedge clk);
    bus.iocs   = 1'b0;

    // Default divisor: 0xB4 starts 0,0,0,1 so txd stays low 3 bits = 31248 clks.
    applyStimulus(2'b00, 8'hB4);
    checkOutput("tbr drop default", bus.tbr, 1'b0);
    waitTxdLow("txd start default", 2000);
    lowClks = 0;
    while (txd === 1'b0 && lowClks < 40000) begin
      lowClks++;
      @(negedge clk);
    end
    checkOutput("default low run clks", lowClks, 31248);
    checkOutput("tbr busy mid frame", bus.tbr, 1'b0);

    // Reset mid-frame returns tbr/txd at once, without waiting for a clock.
    rst = 1'b1;
    #1;
    checkOutput("async reset tbr", bus.tbr, 1'b1);
    checkOutput("async reset txd", txd, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Fast divisor 4: 64 clocks per bit.
    applyStimulus(2'b10, 8'h04);
    applyStimulus(2'b11, 8'h00);
    readCheck("div low written", 2'b10, 8'h04);
    readCheck("div high written", 2'b11, 8'h00);

    // Loopback of 0xB4 with bit-centre sampling of txd.
    loopEn = 1'b1;
    applyStimulus(2'b00, 8'hB4);
    waitTxdLow("txd start loop", 200);
    repeat (BIT_CLKS / 2) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      txFrame[i] = txd;
      if (i < 9) repeat (BIT_CLKS) @(negedge clk);
    end
    checkOutput("tx frame B4", txFrame, 10'b1101101000);
    waitRda("loop rda rise", 300);
    readCheck("loop rx byte", 2'b00, 8'hB4);
    checkOutput("rda cleared after read", bus.rda, 1'b0);
    waitTbr("tbr back after stop", 300);

    // Second write while busy is ignored.
    applyStimulus(2'b00, 8'h55);
    applyStimulus(2'b00, 8'hAA);
    readCheck("status while busy", 2'b01, 8'h00);
    waitRda("busy rda rise", 1500);
    readCheck("busy rx byte", 2'b00, 8'h55);
    repeat (1500) @(negedge clk);
    checkOutput("no second frame rda", bus.rda, 1'b0);
    checkOutput("no second frame tbr", bus.tbr, 1'b1);

    // Bench-driven frames and overrun.
    loopEn = 1'b0;
    rxDrive = 1'b1;
    repeat (20) @(negedge clk);
    sendSerial(8'h3C, 1'b1, BIT_CLKS);
    waitRda("rx 3C rda", 100);
    sendSerial(8'hC3, 1'b1, BIT_CLKS);
    readCheck("status overrun", 2'b01, 8'h03);
    readCheck("overrun byte", 2'b00, 8'hC3);
    checkOutput("rda clear after overrun", bus.rda, 1'b0);

    // Short low glitch is rejected.
    rxDrive = 1'b0;
    repeat (20) @(negedge clk);
    rxDrive = 1'b1;
    repeat (300) @(negedge clk);
    checkOutput("glitch no rda", bus.rda, 1'b0);

    // Framing error (stop bit low) drops the byte.
    sendSerial(8'hA5, 1'b0, 44);
    repeat (700) @(negedge clk);
    checkOutput("framing error no rda", bus.rda, 1'b0);
    readCheck("framing error buffer kept", 2'b00, 8'hC3);

    // Receiver still works afterwards.
    sendSerial(8'h5A, 1'b1, BIT_CLKS);
    waitRda("rx 5A rda", 100);
    readCheck("rx 5A byte", 2'b00, 8'h5A);

    // Reset while both directions are mid-frame with txd low.
    loopEn = 1'b1;
    applyStimulus(2'b00, 8'h00);
    waitTxdLow("txd start abort", 200);
    repeat (100) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("abort reset txd", txd, 1'b1);
    checkOutput("abort reset tbr", bus.tbr, 1'b1);
    checkOutput("abort reset rda", bus.rda, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    readCheck("abort div restored", 2'b10, 8'h8B);
    repeat (2000) @(negedge clk);
    checkOutput("abort no partial byte", bus.rda, 1'b0);
    readCheck("abort buffer cleared", 2'b00, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spart.md
SPART -- requirements
Module: spart

Interface
REQ-001 SHALL have parameter DEFAULT_DIVISOR, 16'h028B, divisor loaded at reset (4800 baud, 16x oversample, 50 MHz clk).
REQ-002 SHALL have port clk  input  1  system clock; all sequential logic on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port iocs  input  1  chip select; bus accesses occur only when high.
REQ-005 SHALL have port iorw  input  1  1 = read (SPART drives databus), 0 = write.
REQ-006 SHALL have port ioaddr  input  2  register select: 00 TX/RX buffer, 01 status, 10 divisor low byte, 11 divisor high byte.
REQ-007 SHALL have port databus  inout  8  bidirectional data bus.
REQ-008 SHALL have port rda  output  1  receive data available.
REQ-009 SHALL have port tbr  output  1  transmit buffer ready.
REQ-010 SHALL have port txd  output  1  serial out; idle high.
REQ-011 SHALL have port rxd  input  1  serial in; idle high.

Function
REQ-012 SHALL drive databus only while iocs=1 and iorw=1; otherwise high-Z.
REQ-013 SHALL return on reads: 00 -> last received byte; 01 -> {6'b0, tbr, rda}; 10/11 -> divisor low/high byte.
REQ-014 SHALL on write (iocs=1, iorw=0) at 10/11 load divisor low/high byte on that clock edge and restart the baud counter.
REQ-015 SHALL generate a one-clk baud enable every max(divisor,1) clocks (counter reloads divisor-1, pulses at 0); 16 enables = one bit time.
REQ-016 SHALL frame 8N1: start bit 0, 8 data bits LSB first, stop bit 1.
REQ-017 SHALL on write to 00 while tbr=1 latch databus, drop tbr the next cycle and start the TX frame at the next baud enable.
REQ-018 SHALL ignore writes to 00 while tbr=0 (byte not latched, frame undisturbed).
REQ-019 SHALL TX FSM: IDLE (txd=1, tbr=1) -> START -> DATA (8 bits) -> STOP -> IDLE; each state bit lasts 16 enables; tbr rises when STOP completes.
REQ-020 SHALL synchronise rxd through two flops before use.
REQ-021 SHALL RX FSM: IDLE -> START on synced rxd low; at 8th enable, rxd still low -> DATA, else back to IDLE (glitch reject).
REQ-022 SHALL sample each data bit at 16-enable intervals from start-bit centre, shifting LSB first.
REQ-023 SHALL in STOP sample at bit centre: 1 -> store byte in RX buffer and set rda; 0 (framing error) -> discard byte, rda unchanged; then IDLE.
REQ-024 SHALL clear rda on the clock after a read of 00; a new byte completing the same cycle wins (rda stays 1, new byte stored).
REQ-025 SHALL on overrun (new byte while rda=1) overwrite RX buffer, rda stays 1.
REQ-026 SHALL run TX and RX independently and concurrently (full duplex).

Reset
REQ-027 SHALL on rst asynchronously force: txd=1, tbr=1, rda=0, RX buffer=8'h00, TX/RX FSMs IDLE, baud counter reloaded, divisor=DEFAULT_DIVISOR, databus high-Z.
REQ-028 SHALL abort any frame in progress when rst asserts mid-frame; no partial byte delivered after release.

Verification
REQ-029 SHALL loopback (txd->rxd): write 10<-8'h8B, 11<-8'h02, 00<-8'hB4 -> tbr low, rda rises ~10 bit times later, read 00 returns 8'hB4, rda clears next cycle, tbr back to 1.
REQ-030 SHALL TX timing, divisor 16'h028B: each txd bit lasts 16*651=10416 clks; 8'hB4 yields 0,0,0,1,0,1,1,0,1,1.
REQ-031 SHALL status/bus: after reset, read 01 -> 8'h02; iocs=0 or iorw=0 -> databus Z; read 10/11 -> 8'h8B/8'h02.
REQ-032 SHALL busy write: write 8'h55 then 8'hAA while tbr=0 -> only 8'h55 transmitted.
REQ-033 SHALL errors: rxd low pulse < 8 enables -> no rda; frame with stop bit 0 -> no rda; rst asserted mid-TX -> txd=1, tbr=1 immediately.
